// File: rtl/button_conditioner.sv
// Elevator button front end: per-channel two-flop synchronizer, counter debounce,
// rising-edge pulses and a per-floor call latch. Define BTN_CANCEL_EN to let a cabin re-press cancel a call.
module button_conditioner #(
    parameter int unsigned N_FLOORS  = 4,
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] btn_in,
    input  logic [N_FLOORS-1:0] btn_out,
    input  logic                btn_open,
    input  logic                btn_close,
    input  logic                btn_sos,
    input  logic [N_FLOORS-1:0] arrived,
    input  logic                door_open,
    output logic [N_FLOORS-1:0] in_pulse,
    output logic [N_FLOORS-1:0] out_pulse,
    output logic                open_pulse,
    output logic                close_pulse,
    output logic                sos_level,
    output logic [N_FLOORS-1:0] call_pending
);
    // Channel order, LSB first: cabin floors, hall floors, open, close, sos.
    localparam int unsigned N_CH     = 2 * N_FLOORS + 3;
    localparam int unsigned PULSE_W  = N_CH - 1;
    localparam int unsigned CH_OPEN  = 2 * N_FLOORS;
    localparam int unsigned CH_CLOSE = CH_OPEN + 1;
    localparam int unsigned CH_SOS   = CH_OPEN + 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
`ifdef BTN_CANCEL_EN
    localparam logic CANCEL_EN = 1'b1;
`else
    localparam logic CANCEL_EN = 1'b0;
`endif

    logic [N_CH-1:0]     raw;
    logic [N_CH-1:0]     sync1_q, sync1_d;
    logic [N_CH-1:0]     sync2_q, sync2_d;
    logic [N_CH-1:0]     db_q, db_d;
    logic [CNT_W-1:0]    cnt_q [N_CH];
    logic [CNT_W-1:0]    cnt_d [N_CH];
    logic [PULSE_W-1:0]  db_dly_q, db_dly_d;
    logic [PULSE_W-1:0]  pulse_q, pulse_d;
    logic [N_FLOORS-1:0] pend_q, pend_d;

    assign raw = {btn_sos, btn_close, btn_open, btn_out, btn_in};

    // Synchronizer and debounce: accept a new level only after DB_CYCLES unbroken cycles of it.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int unsigned c = 0; c < N_CH; c++) begin
            cnt_d[c] = '0;
            if (sync2_q[c] != db_q[c]) begin
                if (cnt_q[c] == CNT_LAST) begin
                    db_d[c] = sync2_q[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    // Rising-edge pulses; the SOS channel is a level and needs no edge detect.
    always_comb begin
        db_dly_d = db_q[PULSE_W-1:0];
        pulse_d  = db_q[PULSE_W-1:0] & ~db_dly_q;
    end

    // Service at the current open-door floor beats any press on that floor.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (arrived[i] && door_open) begin
                pend_d[i] = 1'b0;
            end else if (CANCEL_EN && pend_q[i] && pulse_q[i] && !pulse_q[N_FLOORS+i]) begin
                pend_d[i] = 1'b0;
            end else if (pulse_q[i] || pulse_q[N_FLOORS+i]) begin
                pend_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
            pulse_q  <= '0;
            pend_q   <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
            pulse_q  <= pulse_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_pulse     = pulse_q[N_FLOORS-1:0];
    assign out_pulse    = pulse_q[2*N_FLOORS-1:N_FLOORS];
    assign open_pulse   = pulse_q[CH_OPEN];
    assign close_pulse  = pulse_q[CH_CLOSE];
    assign sos_level    = db_q[CH_SOS];
    assign call_pending = pend_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner (DB_CYCLES=4): vector table, directed corner sequences,
// and random stimulus against a history-window reference model. Honours BTN_CANCEL_EN.
module tb_button_conditioner;
    localparam int N    = 4;
    localparam int DB   = 4;
    localparam int NCH  = 2 * N + 3;
    localparam int PW   = NCH - 1;
    localparam int MAXE = 8192;
`ifdef BTN_CANCEL_EN
    localparam bit CANCEL = 1'b1;
`else
    localparam bit CANCEL = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] raw_drv = '0;
    logic [N-1:0]   arrived = '0;
    logic           door_open = 1'b0;
    logic [N-1:0]   in_pulse, out_pulse, call_pending;
    logic           open_pulse, close_pulse, sos_level;
    logic [NCH-1:0] obs;

    int errors = 0;
    int checks = 0;

    button_conditioner #(.N_FLOORS(N), .DB_CYCLES(DB), .CNT_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (raw_drv[N-1:0]),
        .btn_out      (raw_drv[2*N-1:N]),
        .btn_open     (raw_drv[2*N]),
        .btn_close    (raw_drv[2*N+1]),
        .btn_sos      (raw_drv[2*N+2]),
        .arrived      (arrived),
        .door_open    (door_open),
        .in_pulse     (in_pulse),
        .out_pulse    (out_pulse),
        .open_pulse   (open_pulse),
        .close_pulse  (close_pulse),
        .sos_level    (sos_level),
        .call_pending (call_pending)
    );

    always #5 clk = ~clk;

    assign obs = {sos_level, close_pulse, open_pulse, out_pulse, in_pulse};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: histories indexed by clock edge. A channel's accepted level becomes v
    // once the synchronized input has read v for DB consecutive cycles.
    bit [NCH-1:0] raw_h [MAXE];
    bit [NCH-1:0] s_h   [MAXE];
    bit [NCH-1:0] db_h  [MAXE];
    bit [PW-1:0]  pl_h  [MAXE];
    bit [N-1:0]   pd_h  [MAXE];
    int t = 8;

    always begin
        @(posedge clk);
        t = t + 1;
        if (t >= MAXE) begin
            $display("FAIL model_overflow: got edge %0d expected below %0d", t, MAXE);
            $fatal(1, "model history exhausted");
        end
        if (!rst) begin
            raw_h[t] = '0;
            s_h[t]   = '0;
            db_h[t]  = '0;
            pl_h[t]  = '0;
            pd_h[t]  = '0;
        end else begin
            raw_h[t] = raw_drv;
            s_h[t]   = raw_h[t-1];
            for (int c = 0; c < NCH; c++) begin
                bit steady;
                steady = 1'b1;
                for (int k = 2; k <= DB; k++)
                    if (s_h[t-k][c] != s_h[t-1][c]) steady = 1'b0;
                db_h[t][c] = steady ? s_h[t-1][c] : db_h[t-1][c];
            end
            pl_h[t] = db_h[t-1][PW-1:0] & ~db_h[t-2][PW-1:0];
            for (int i = 0; i < N; i++) begin
                bit pin, pout;
                pin  = pl_h[t-1][i];
                pout = pl_h[t-1][N+i];
                if (arrived[i] && door_open)             pd_h[t][i] = 1'b0;
                else if (CANCEL && pin && !pout && pd_h[t-1][i]) pd_h[t][i] = 1'b0;
                else if (pin || pout)                    pd_h[t][i] = 1'b1;
                else                                     pd_h[t][i] = pd_h[t-1][i];
            end
        end
        #1;
        chk("model", 32'({call_pending, sos_level, close_pulse, open_pulse, out_pulse, in_pulse}),
            32'({pd_h[t], db_h[t][NCH-1], pl_h[t]}));
    end

    task automatic do_reset();
        @(negedge clk);
        raw_drv = '0; arrived = '0; door_open = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic press(input int ch, input int hold, input int gap);
        @(negedge clk);
        raw_drv[ch] = 1'b1;
        repeat (hold) @(negedge clk);
        raw_drv[ch] = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    typedef struct {
        int         ch;
        int         hold;
        int         exp_cnt;
        logic [3:0] exp_pend;
    } vec_t;

    vec_t tbl [9];
    int   hc  [NCH];

    initial begin
        int n, n_open, n_in, n_sos, at_open, at_in;

        // channel, raw-high edges, cycles the channel's output is high, final call_pending
        tbl[0] = '{2,  10, 1, 4'b0100};
        tbl[1] = '{5,  3,  0, 4'b0000};
        tbl[2] = '{5,  4,  1, 4'b0010};
        tbl[3] = '{0,  1,  0, 4'b0000};
        tbl[4] = '{8,  6,  1, 4'b0000};
        tbl[5] = '{9,  4,  1, 4'b0000};
        tbl[6] = '{10, 8,  8, 4'b0000};
        tbl[7] = '{10, 3,  0, 4'b0000};
        tbl[8] = '{7,  20, 1, 4'b1000};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(obs), 32'd0);
        chk("reset_pending", 32'(call_pending), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[v]) begin
            do_reset();
            n = 0;
            for (int k = 0; k < tbl[v].hold + 16; k++) begin
                @(negedge clk);
                raw_drv[tbl[v].ch] = (k < tbl[v].hold);
                @(posedge clk);
                #1;
                if (obs[tbl[v].ch]) n++;
            end
            chk($sformatf("vec%0d_count", v), 32'(n), 32'(tbl[v].exp_cnt));
            chk($sformatf("vec%0d_pending", v), 32'(call_pending), 32'(tbl[v].exp_pend));
        end

        // Clean press: pulse exactly after edge 2+DB.
        do_reset();
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k == 0) raw_drv[2] = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("clean_in_pulse_e%0d", k), 32'(in_pulse), (k == 6) ? 32'h4 : 32'h0);
        end
        chk("clean_pending", 32'(call_pending), 32'h4);

        // Bounce: two cycles high, two low, never accepted.
        do_reset();
        n = 0;
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            raw_drv[5] = (k < 20) && ((k / 2) % 2 == 0);
            @(posedge clk);
            #1;
            if (out_pulse != '0) n++;
        end
        chk("bounce_out_pulses", 32'(n), 32'd0);
        chk("bounce_pending", 32'(call_pending), 32'd0);

        // Service clear, then a press on the serviced floor is absorbed.
        do_reset();
        press(3, 8, 12);
        chk("service_set", 32'(call_pending), 32'h8);
        @(negedge clk);
        arrived = 4'b1000; door_open = 1'b1;
        @(posedge clk);
        #1;
        chk("service_clear", 32'(call_pending), 32'h0);
        n = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            raw_drv[3] = (k < 8);
            @(posedge clk);
            #1;
            if (in_pulse[3]) n++;
        end
        chk("service_press_pulsed", 32'(n), 32'd1);
        chk("service_absorbed", 32'(call_pending), 32'h0);
        @(negedge clk);
        arrived = '0; door_open = 1'b0;
        @(posedge clk);
        #1;
        chk("service_after", 32'(call_pending), 32'h0);

        // Simultaneous channels pulse together; SOS untouched.
        do_reset();
        at_open = -1; at_in = -1; n_open = 0; n_in = 0; n_sos = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 0) begin raw_drv[8] = 1'b1; raw_drv[0] = 1'b1; end
            @(posedge clk);
            #1;
            if (open_pulse)  begin n_open++; at_open = k; end
            if (in_pulse[0]) begin n_in++;   at_in = k;   end
            if (sos_level)   n_sos++;
        end
        chk("simul_open_edge", 32'(at_open), 32'd6);
        chk("simul_in_edge", 32'(at_in), 32'd6);
        chk("simul_counts", 32'({n_open[7:0], n_in[7:0]}), 32'h0101);
        chk("simul_sos", 32'(n_sos), 32'd0);

        // Reset while a close press is debouncing; pending call cleared by reset.
        do_reset();
        press(1, 6, 12);
        chk("rst_pre_pending", 32'(call_pending), 32'h2);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) raw_drv[9] = 1'b1;
            if (k == 3) rst = 1'b0;
            if (k == 5) rst = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("rst_close_e%0d", k), 32'(close_pulse), (k == 11) ? 32'd1 : 32'd0);
            if (k == 3 || k == 4) chk($sformatf("rst_pending_e%0d", k), 32'(call_pending), 32'd0);
        end
        @(negedge clk);
        raw_drv[9] = 1'b0;

        // Re-press on a pending floor.
        do_reset();
        press(3, 6, 14);
        chk("repress_first", 32'(call_pending[3]), 32'd1);
        press(3, 6, 14);
        chk("repress_second", 32'(call_pending[3]), CANCEL ? 32'd0 : 32'd1);

        // Random: per-channel random hold lengths, random service and occasional reset.
        do_reset();
        for (int c = 0; c < NCH; c++) hc[c] = int'($urandom_range(0, 8));
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if (hc[c] == 0) begin
                    raw_drv[c] = ~raw_drv[c];
                    hc[c] = int'($urandom_range(0, 8));
                end else begin
                    hc[c]--;
                end
            end
            door_open = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0:       arrived = 4'(1 << $urandom_range(0, 3));
                1:       arrived = 4'($urandom_range(0, 15));
                default: arrived = '0;
            endcase
            rst = ($urandom_range(0, 149) != 0);
        end
        @(negedge clk);
        rst = 1'b1; raw_drv = '0;
        repeat (2) @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
